// File: rtl/vit_dec_trb_decision_tree.sv
// Viterbi traceback start-state decision: pipelined modular-compare argmax tree with forced-start bypass.
// Optional ometric path enabled by VIT_DEC_TRB_DECISION_METRIC_OUT_EN (undefined: ometric tied to 0).
module vit_dec_trb_decision_tree #(
  parameter int pSTATE_NUM = 64,
  parameter int pMETRIC_W  = 8,
  parameter int pREG_EVERY = 1
) (
  input  logic                                  iclk,
  input  logic                                  ireset,
  input  logic                                  iclkena,
  input  logic                                  ival,
  input  logic                                  isop,
  input  logic [pSTATE_NUM*pMETRIC_W-1:0]       istatem,
  input  logic                                  iforce,
  input  logic [$clog2(pSTATE_NUM)-1:0]         iforce_state,
  output logic                                  oval,
  output logic                                  osop,
  output logic [$clog2(pSTATE_NUM)-1:0]         ostate,
  output logic [pMETRIC_W-1:0]                  ometric
);

  localparam int cD = $clog2(pSTATE_NUM);
  localparam int cW = pMETRIC_W;
  localparam int cL = (cD + pREG_EVERY - 1) / pREG_EVERY;
`ifdef VIT_DEC_TRB_DECISION_METRIC_OUT_EN
  localparam bit cMETRIC_OUT = 1'b1;
`else
  localparam bit cMETRIC_OUT = 1'b0;
`endif

  logic [pSTATE_NUM*cD-1:0] idx0;

  genvar gs;
  for (gs = 0; gs < pSTATE_NUM; gs++) begin : g_idx0
    assign idx0[gs*cD +: cD] = cD'(gs);
  end

  // Each level halves the candidate set; the winner of a pair is the lower index unless
  // the higher one is strictly ahead in wrap-around order.
  genvar gi;
  for (gi = 0; gi < cD; gi++) begin : g_lvl
    localparam int cN       = pSTATE_NUM >> (gi + 1);
    localparam bit cREG     = (((gi + 1) % pREG_EVERY) == 0) || (gi == cD - 1);
    localparam bit cKEEP_M  = (gi < cD - 1) || cMETRIC_OUT;

    logic [2*cN*cW-1:0] in_m;
    logic [2*cN*cD-1:0] in_i;
    logic [cN-1:0]      win;
    logic [cW-1:0]      diff;
    logic [cN*cD-1:0]   c_i;
    logic [cN*cD-1:0]   out_i;

    if (gi == 0) begin : g_src
      assign in_m = istatem;
      assign in_i = idx0;
    end else begin : g_src
      assign in_m = g_lvl[gi-1].g_met.out_m;
      assign in_i = g_lvl[gi-1].out_i;
    end

    always_comb begin
      diff = '0;
      win  = '0;
      c_i  = '0;
      for (int j = 0; j < cN; j++) begin
        diff   = in_m[2*j*cW +: cW] - in_m[(2*j+1)*cW +: cW];
        win[j] = ~diff[cW-1];
        c_i[j*cD +: cD] = win[j] ? in_i[2*j*cD +: cD] : in_i[(2*j+1)*cD +: cD];
      end
    end

    if (cREG) begin : g_reg
      always_ff @(posedge iclk or posedge ireset) begin
        if (ireset)       out_i <= '0;
        else if (iclkena) out_i <= c_i;
      end
    end else begin : g_comb
      assign out_i = c_i;
    end

    if (cKEEP_M) begin : g_met
      logic [cN*cW-1:0] c_m;
      logic [cN*cW-1:0] out_m;

      always_comb begin
        c_m = '0;
        for (int j = 0; j < cN; j++)
          c_m[j*cW +: cW] = win[j] ? in_m[2*j*cW +: cW] : in_m[(2*j+1)*cW +: cW];
      end

      if (cREG) begin : g_reg
        always_ff @(posedge iclk or posedge ireset) begin
          if (ireset)       out_m <= '0;
          else if (iclkena) out_m <= c_m;
        end
      end else begin : g_comb
        assign out_m = c_m;
      end
    end
  end

  // Sideband delay line, one stage per registered tree level.
  logic [cL-1:0] sb_val;
  logic [cL-1:0] sb_sop;
  logic [cL-1:0] sb_frc;
  logic [cD-1:0] sb_fst [cL];

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      sb_val <= '0;
      sb_sop <= '0;
      sb_frc <= '0;
      for (int k = 0; k < cL; k++) sb_fst[k] <= '0;
    end else if (iclkena) begin
      sb_val[0] <= ival;
      sb_sop[0] <= isop & ival;
      sb_frc[0] <= iforce;
      sb_fst[0] <= iforce_state;
      for (int k = 1; k < cL; k++) begin
        sb_val[k] <= sb_val[k-1];
        sb_sop[k] <= sb_sop[k-1];
        sb_frc[k] <= sb_frc[k-1];
        sb_fst[k] <= sb_fst[k-1];
      end
    end
  end

  assign oval   = sb_val[cL-1];
  assign osop   = sb_sop[cL-1];
  assign ostate = sb_frc[cL-1] ? sb_fst[cL-1] : g_lvl[cD-1].out_i;

`ifdef VIT_DEC_TRB_DECISION_METRIC_OUT_EN
  logic [cW-1:0] fmet;
  logic [cW-1:0] sb_fmet [cL];

  always_comb begin
    fmet = '0;
    for (int s = 0; s < pSTATE_NUM; s++)
      if (iforce_state == cD'(s)) fmet = istatem[s*cW +: cW];
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      for (int k = 0; k < cL; k++) sb_fmet[k] <= '0;
    end else if (iclkena) begin
      sb_fmet[0] <= fmet;
      for (int k = 1; k < cL; k++) sb_fmet[k] <= sb_fmet[k-1];
    end
  end

  assign ometric = sb_frc[cL-1] ? sb_fmet[cL-1] : g_lvl[cD-1].g_met.out_m;
`else
  assign ometric = '0;
`endif

endmodule

// File: tb/tb_vit_dec_trb_decision_tree.sv
// Directed bench: three instances (N=64 R=1 latency 6, N=64 R=3 latency 2, N=2 latency 1) on shared stimulus.
module tb_vit_dec_trb_decision_tree;

`ifdef VIT_DEC_TRB_DECISION_METRIC_OUT_EN
  localparam bit MOUT = 1'b1;
`else
  localparam bit MOUT = 1'b0;
`endif

  logic         iclk = 1'b0;
  logic         ireset;
  logic         iclkena;
  logic         ival;
  logic         isop;
  logic         iforce;
  logic [511:0] istatem;
  logic [5:0]   fst;

  logic       a_val, a_sop, b_val, b_sop, c_val, c_sop;
  logic [5:0] a_state, b_state;
  logic [0:0] c_state;
  logic [7:0] a_met, b_met, c_met;

  int checks   = 0;
  int failures = 0;

  always #5 iclk = ~iclk;

  vit_dec_trb_decision_tree #(.pSTATE_NUM(64), .pMETRIC_W(8), .pREG_EVERY(1)) dut_a (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
    .istatem(istatem), .iforce(iforce), .iforce_state(fst),
    .oval(a_val), .osop(a_sop), .ostate(a_state), .ometric(a_met));

  vit_dec_trb_decision_tree #(.pSTATE_NUM(64), .pMETRIC_W(8), .pREG_EVERY(3)) dut_b (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
    .istatem(istatem), .iforce(iforce), .iforce_state(fst),
    .oval(b_val), .osop(b_sop), .ostate(b_state), .ometric(b_met));

  vit_dec_trb_decision_tree #(.pSTATE_NUM(2), .pMETRIC_W(8), .pREG_EVERY(1)) dut_c (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
    .istatem(istatem[15:0]), .iforce(iforce), .iforce_state(fst[0:0]),
    .oval(c_val), .osop(c_sop), .ostate(c_state), .ometric(c_met));

  typedef struct {
    int base;
    int s0i; int s0v;
    int s1i; int s1v;
    int frc; int fs; int sop;
    int est; int emet;
  } vec_t;

  vec_t tv [10];

  function automatic int em(input int m);
    return MOUT ? m : 0;
  endfunction

  function automatic int metric_of(input vec_t v, input int s);
    int m;
    m = v.base;
    if (s == v.s0i) m = v.s0v;
    if (s == v.s1i) m = v.s1v;
    return m;
  endfunction

  // Two-state instance: direct modular compare of states 0 and 1.
  task automatic exp2(input vec_t v, output int st, output int me);
    int m0, m1, d;
    m0 = metric_of(v, 0);
    m1 = metric_of(v, 1);
    if (v.frc != 0) st = v.fs % 2;
    else begin
      d  = (m0 - m1) & 255;
      st = ((d & 128) != 0) ? 1 : 0;
    end
    me = (st == 1) ? m1 : m0;
  endtask

  task automatic drive(input vec_t v, input bit valid);
    for (int s = 0; s < 64; s++) istatem[s*8 +: 8] = 8'(metric_of(v, s));
    iforce = (v.frc != 0);
    fst    = 6'(v.fs);
    ival   = valid;
    isop   = (v.sop != 0);
  endtask

  task automatic step();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input int d, input int ev, input int es,
                         input int est, input int emet);
    logic [31:0] v, s, st, m;
    case (d)
      0:       begin v = 32'(a_val); s = 32'(a_sop); st = 32'(a_state); m = 32'(a_met); end
      1:       begin v = 32'(b_val); s = 32'(b_sop); st = 32'(b_state); m = 32'(b_met); end
      default: begin v = 32'(c_val); s = 32'(c_sop); st = 32'(c_state); m = 32'(c_met); end
    endcase
    chk({nm, ".oval"},    v,  32'(ev));
    chk({nm, ".osop"},    s,  32'(es));
    chk({nm, ".ostate"},  st, 32'(est));
    chk({nm, ".ometric"}, m,  32'(em(emet)));
  endtask

  initial begin
    int st2, me2;

    //          base s0i s0v  s1i  s1v frc fs sop est emet
    tv[0] = '{  10,  37,  50,  -1,   0, 0,  0, 1,  37,  50};
    tv[1] = '{  20,   5, 100,   9, 100, 0,  0, 0,   5, 100};
    tv[2] = '{ 250,   3,   2,  -1,   0, 0,  0, 1,   3,   2};
    tv[3] = '{ 100,  12, 200,   0,   7, 1,  0, 1,   0,   7};
    tv[4] = '{ 100,  12, 200,   0,   7, 0,  0, 0,  12, 200};
    tv[5] = '{   0,  -1,   0,  -1,   0, 0,  0, 1,   0,   0};
    tv[6] = '{   0,  63,   1,  -1,   0, 0,  0, 0,  63,   1};
    tv[7] = '{   5,  10,   9,  -1,   0, 1, 63, 1,  63,   5};
    tv[8] = '{ 200,   0,  70,  -1,   0, 0,  0, 0,   0,  70};
    tv[9] = '{ 127,  62, 128,  63, 129, 0,  0, 1,  63, 129};

    ireset  = 1'b1;
    iclkena = 1'b1;
    ival    = 1'b0;
    isop    = 1'b0;
    iforce  = 1'b0;
    fst     = '0;
    istatem = '0;

    step();
    step();
    chk_dut("reset.a", 0, 0, 0, 0, 0);
    chk_dut("reset.b", 1, 0, 0, 0, 0);
    chk_dut("reset.c", 2, 0, 0, 0, 0);
    ireset = 1'b0;
    repeat (7) step();
    chk_dut("idle.a", 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      drive(tv[i], 1'b1);
      step();
      exp2(tv[i], st2, me2);
      chk_dut($sformatf("vec%0d.c", i), 2, 1, tv[i].sop, st2, me2);
      ival = 1'b0;
      isop = 1'b0;
      step();
      chk_dut($sformatf("vec%0d.b", i), 1, 1, tv[i].sop, tv[i].est, tv[i].emet);
      repeat (4) step();
      chk_dut($sformatf("vec%0d.a", i), 0, 1, tv[i].sop, tv[i].est, tv[i].emet);
    end

    // Back-to-back stream with a three-clock enable gap.
    drive(tv[0], 1'b1); step();
    chk("stream.b.e0.oval", 32'(b_val), 32'(0));
    drive(tv[1], 1'b1); step();
    chk_dut("stream.b.e1", 1, 1, tv[0].sop, tv[0].est, tv[0].emet);
    drive(tv[2], 1'b1); step();
    chk_dut("stream.b.e2", 1, 1, tv[1].sop, tv[1].est, tv[1].emet);
    iclkena = 1'b0;
    drive(tv[3], 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_dut($sformatf("stream.b.hold%0d", k), 1, 1, tv[1].sop, tv[1].est, tv[1].emet);
    end
    iclkena = 1'b1;
    drive(tv[4], 1'b1); step();
    chk_dut("stream.b.e6", 1, 1, tv[2].sop, tv[2].est, tv[2].emet);
    ival = 1'b0; isop = 1'b0; step();
    chk_dut("stream.b.e7", 1, 1, tv[4].sop, tv[4].est, tv[4].emet);
    chk("stream.a.e7.oval", 32'(a_val), 32'(0));
    step();
    chk("stream.b.e8.oval", 32'(b_val), 32'(0));
    chk_dut("stream.a.e8", 0, 1, tv[0].sop, tv[0].est, tv[0].emet);
    step();
    chk_dut("stream.a.e9", 0, 1, tv[1].sop, tv[1].est, tv[1].emet);
    step();
    chk_dut("stream.a.e10", 0, 1, tv[2].sop, tv[2].est, tv[2].emet);
    step();
    chk_dut("stream.a.e11", 0, 1, tv[4].sop, tv[4].est, tv[4].emet);
    step();
    chk("stream.a.e12.oval", 32'(a_val), 32'(0));

    // Reset in the middle of a stream.
    drive(tv[0], 1'b1); step();
    drive(tv[1], 1'b1); step();
    chk_dut("rst.pre.b", 1, 1, tv[0].sop, tv[0].est, tv[0].emet);
    ireset = 1'b1;
    #1;
    chk_dut("rst.now.b", 1, 0, 0, 0, 0);
    chk_dut("rst.now.a", 0, 0, 0, 0, 0);
    @(negedge iclk);
    ireset = 1'b0;
    drive(tv[2], 1'b1); step();
    chk("rst.r0.b.oval", 32'(b_val), 32'(0));
    chk("rst.r0.b.osop", 32'(b_sop), 32'(0));
    ival = 1'b0; isop = 1'b0; step();
    chk_dut("rst.r1.b", 1, 1, 1, tv[2].est, tv[2].emet);
    for (int k = 2; k < 5; k++) begin
      step();
      chk($sformatf("rst.r%0d.a.oval", k), 32'(a_val), 32'(0));
    end
    step();
    chk_dut("rst.r5.a", 0, 1, 1, tv[2].est, tv[2].emet);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
